// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit holding HI/LO; one result bit per cycle on a shared accumulator.
// Define MULTDIV_DIV_EN to build the restoring divider; without it divide ops end with err set.
module mult_div_unit #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);
    // Handshake: start is a one-cycle request accepted only in IDLE; busy stays high until the
    // cycle in which done pulses, and a new start may be presented during that done cycle.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

    state_t               state, state_next;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mcand;
    logic [CNT_W-1:0]     cnt;
    logic                 neg_res;
    logic                 fault;

    logic                 is_signed;
    logic                 quick_fin;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   prod_fix;

    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign is_signed = ~op[0];
    assign abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;

    // Multiply step: conditional add into the upper half, then shift {carry, acc} right.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    assign prod_fix = neg_res ? -acc : acc;

`ifdef MULTDIV_DIV_EN
    logic                 is_div;
    logic                 neg_rem;
    logic [WIDTH:0]       rem_sh;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // Restoring step: the shifted remainder needs WIDTH+1 bits before the trial subtract.
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign div_ge   = (rem_sh >= {1'b0, mcand});
    assign div_diff = rem_sh[WIDTH-1:0] - mcand;
    assign div_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign quick_fin = op[1] && (b == {WIDTH{1'b0}});
`else
    assign quick_fin = op[1];
`endif

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = quick_fin ? FIN : RUN;
            RUN:     if (cnt == CNT_W'(1)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            fault   <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef MULTDIV_DIV_EN
            is_div  <= 1'b0;
            neg_rem <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err     <= 1'b0;
                        fault   <= quick_fin;
                        cnt     <= CNT_W'(WIDTH);
                        neg_res <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULTDIV_DIV_EN
                        is_div  <= op[1];
                        neg_rem <= is_signed && a[WIDTH-1];
                        if (op[1]) begin
                            mcand <= abs_b;
                            // Divide by zero writes back HI = a, LO = all ones straight from acc.
                            acc   <= quick_fin ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, abs_a};
                        end else begin
                            mcand <= abs_a;
                            acc   <= {{WIDTH{1'b0}}, abs_b};
                        end
`else
                        mcand <= abs_a;
                        acc   <= {{WIDTH{1'b0}}, abs_b};
`endif
                    end else if (hilo_we) begin
                        if (hilo_sel) hi <= wdata;
                        else          lo <= wdata;
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
`ifdef MULTDIV_DIV_EN
                    acc <= is_div ? div_next : mul_next;
`else
                    acc <= mul_next;
`endif
                end
                FIN: begin
                    done <= 1'b1;
                    if (fault) begin
                        err <= 1'b1;
`ifdef MULTDIV_DIV_EN
                        {hi, lo} <= acc;
`endif
                    end
`ifdef MULTDIV_DIV_EN
                    else if (is_div) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end
`endif
                    else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: timing, arithmetic, error, reset and HI/LO write cases.
// Divide expectations follow whether MULTDIV_DIV_EN is defined for the build.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hilo_we = 1'b0;
  logic         hilo_sel = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, done, err;
  logic [W-1:0] hi, lo;
  logic [1:0]   state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .hi(hi), .lo(lo), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // driver tasks: called at #1 after a rising edge; issue returns at #1 after E0
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge Clk); #1;
      if (done === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    reset = 1'b0;
    tests_run += 6;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
    if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", err); end
    if (hi !== 32'h0) begin tests_failed++; $display("FAIL reset_hi got %h want 0", hi); end
    if (lo !== 32'h0) begin tests_failed++; $display("FAIL reset_lo got %h want 0", lo); end
    if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", state_dbg); end
  endtask

  task automatic test_multu();
    int e;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL multu_busy_e0 got %b want 1", busy); end
    wait_done(e);
    tests_run += 5;
    if (e !== W + 1) begin tests_failed++; $display("FAIL multu_latency got %0d want %0d", e, W + 1); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL multu_busy_done got %b want 0", busy); end
    if (hi !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    if (lo !== 32'h0000_0001) begin tests_failed++; $display("FAIL multu_lo got %h want 00000001", lo); end
    if (err !== 1'b0) begin tests_failed++; $display("FAIL multu_err got %b want 0", err); end
    @(posedge Clk); #1;
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL multu_done_width got %b want 0", done); end
  endtask

  task automatic test_mult();
    int e;
    issue(2'b00, 32'hFFFF_FFF9, 32'd3);
    wait_done(e);
    tests_run += 3;
    if (e !== W + 1) begin tests_failed++; $display("FAIL mult_latency got %0d want %0d", e, W + 1); end
    if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    if (lo !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
  endtask

  task automatic test_divide();
    int e;
`ifdef MULTDIV_DIV_EN
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(e);
    tests_run += 4;
    if (e !== W + 1) begin tests_failed++; $display("FAIL div_latency got %0d want %0d", e, W + 1); end
    if (lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_lo got %h want fffffffd", lo); end
    if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div_hi got %h want ffffffff", hi); end
    if (err !== 1'b0) begin tests_failed++; $display("FAIL div_err got %b want 0", err); end
    issue(2'b11, 32'd100, 32'd7);
    wait_done(e);
    tests_run += 2;
    if (lo !== 32'd14) begin tests_failed++; $display("FAIL divu_lo got %h want 0000000e", lo); end
    if (hi !== 32'd2) begin tests_failed++; $display("FAIL divu_hi got %h want 00000002", hi); end
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(e);
    tests_run += 3;
    if (lo !== 32'h8000_0000) begin tests_failed++; $display("FAIL divmin_lo got %h want 80000000", lo); end
    if (hi !== 32'h0) begin tests_failed++; $display("FAIL divmin_hi got %h want 0", hi); end
    if (err !== 1'b0) begin tests_failed++; $display("FAIL divmin_err got %b want 0", err); end
    issue(2'b10, 32'd5, 32'd0);
    wait_done(e);
    tests_run += 4;
    if (e !== 1) begin tests_failed++; $display("FAIL divzero_latency got %0d want 1", e); end
    if (err !== 1'b1) begin tests_failed++; $display("FAIL divzero_err got %b want 1", err); end
    if (hi !== 32'd5) begin tests_failed++; $display("FAIL divzero_hi got %h want 00000005", hi); end
    if (lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL divzero_lo got %h want ffffffff", lo); end
`else
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(e);
    tests_run += 4;
    if (e !== 1) begin tests_failed++; $display("FAIL nodiv_latency got %0d want 1", e); end
    if (err !== 1'b1) begin tests_failed++; $display("FAIL nodiv_err got %b want 1", err); end
    if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL nodiv_hi got %h want ffffffff", hi); end
    if (lo !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL nodiv_lo got %h want ffffffeb", lo); end
`endif
  endtask

  task automatic test_err_hold();
    int e;
    repeat (3) @(posedge Clk);
    #1;
    tests_run++;
    if (err !== 1'b1) begin tests_failed++; $display("FAIL err_hold got %b want 1", err); end
    issue(2'b01, 32'd2, 32'd3);
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL err_clear got %b want 0", err); end
    wait_done(e);
    tests_run++;
    if (lo !== 32'd6) begin tests_failed++; $display("FAIL err_next_lo got %h want 00000006", lo); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    issue(2'b01, 32'd3, 32'd4);
    repeat (10) @(posedge Clk);
    reset = 1'b1;
    #1;
    tests_run += 4;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b want 0", busy); end
    if (hi !== 32'h0) begin tests_failed++; $display("FAIL rstmid_hi got %h want 0", hi); end
    if (lo !== 32'h0) begin tests_failed++; $display("FAIL rstmid_lo got %h want 0", lo); end
    if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL rstmid_state got %0d want 0", state_dbg); end
    @(posedge Clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (done === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL rstmid_no_done got %0d want 0", pulses); end
  endtask

  task automatic test_hilo_write();
    hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge Clk); #1;
    tests_run += 2;
    if (hi !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL mthi_hi got %h want a5a5a5a5", hi); end
    if (lo !== 32'h0) begin tests_failed++; $display("FAIL mthi_lo got %h want 0", lo); end
    hilo_sel = 1'b0; wdata = 32'h1234_5678;
    @(posedge Clk); #1;
    hilo_we = 1'b0;
    tests_run += 2;
    if (lo !== 32'h1234_5678) begin tests_failed++; $display("FAIL mtlo_lo got %h want 12345678", lo); end
    if (hi !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL mtlo_hi got %h want a5a5a5a5", hi); end
  endtask

  task automatic test_hilo_ignored();
    int e;
    hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'h1111_1111;
    issue(2'b01, 32'd2, 32'd3);
    tests_run++;
    if (hi !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL start_wins_hi got %h want a5a5a5a5", hi); end
    hilo_sel = 1'b0; wdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge Clk);
    #1;
    hilo_we = 1'b0;
    wait_done(e);
    tests_run += 2;
    if (lo !== 32'd6) begin tests_failed++; $display("FAIL busy_we_lo got %h want 00000006", lo); end
    if (hi !== 32'h0) begin tests_failed++; $display("FAIL busy_we_hi got %h want 0", hi); end
  endtask

  task automatic test_start_ignored();
    int e;
    int pulses = 0;
    issue(2'b01, 32'd5, 32'd6);
    repeat (4) @(posedge Clk);
    #1;
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    wait_done(e);
    tests_run += 3;
    if (e !== W + 1 - 5) begin tests_failed++; $display("FAIL ignore_latency got %0d want %0d", e, W - 4); end
    if (lo !== 32'd30) begin tests_failed++; $display("FAIL ignore_lo got %h want 0000001e", lo); end
    if (hi !== 32'h0) begin tests_failed++; $display("FAIL ignore_hi got %h want 0", hi); end
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (done === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL ignore_no_second got %0d want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int e;
    issue(2'b01, 32'd2, 32'd3);
    wait_done(e);
    issue(2'b00, 32'd7, 32'hFFFF_FFF8);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept got %b want 1", busy); end
    wait_done(e);
    tests_run += 3;
    if (e !== W + 1) begin tests_failed++; $display("FAIL b2b_latency got %0d want %0d", e, W + 1); end
    if (lo !== 32'hFFFF_FFC8) begin tests_failed++; $display("FAIL b2b_lo got %h want ffffffc8", lo); end
    if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL b2b_hi got %h want ffffffff", hi); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_divide();
    test_err_hold();
    test_reset_mid();
    test_hilo_write();
    test_hilo_ignored();
    test_start_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
